// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, response and memory-side signals around dmem_arbiter.
//   r0_* / r1_*   : request channels (valid/ready handshake, addr, wdata, we, ctl)
//   r*_rsp_valid  : per-owner response strobes; rsp_rdata / rsp_err are shared
//   mem_*         : memory drive (a, wd, we, ctl) and registered read data mem_rd
// Modport slave is the arbiter; modport master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              r0_valid;
    logic              r1_valid;
    logic              r0_ready;
    logic              r1_ready;
    logic [ADDR_W-1:0] r0_addr;
    logic [ADDR_W-1:0] r1_addr;
    logic [31:0]       r0_wdata;
    logic [31:0]       r1_wdata;
    logic              r0_we;
    logic              r1_we;
    logic [2:0]        r0_ctl;
    logic [2:0]        r1_ctl;
    logic              r0_rsp_valid;
    logic              r1_rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic              mem_we;
    logic [2:0]        mem_ctl;
    logic [31:0]       mem_rd;

    modport slave (
        input  r0_valid, r1_valid, r0_addr, r1_addr, r0_wdata, r1_wdata,
        input  r0_we, r1_we, r0_ctl, r1_ctl, mem_rd,
        output r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rsp_rdata, rsp_err,
        output mem_a, mem_wd, mem_we, mem_ctl
    );

    modport master (
        output r0_valid, r1_valid, r0_addr, r1_addr, r0_wdata, r1_wdata,
        output r0_we, r1_we, r0_ctl, r1_ctl, mem_rd,
        input  r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rsp_rdata, rsp_err,
        input  mem_a, mem_wd, mem_we, mem_ctl
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of the byte-addressable data memory.
// r0 is the core load/store path, r1 the debug/DMA port. One access is granted per
// cycle; the response (load data, or an error for illegal accesses) comes back to
// the owner one cycle after acceptance.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dmem_arbiter_if.slave (requests, responses, memory drive)
// Parameters:
//   ERR_EN : 1 = reject misaligned / illegal-ctl accesses with an error response
//   ADDR_W : request and memory address width
module dmem_arbiter #(
    parameter bit ERR_EN = 1'b1,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [1:0]        req_legal;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [31:0]       req_wdata [2];
    logic [2:0]        req_ctl   [2];

    logic [1:0]        grant;
    logic              sel;
    logic              any_grant;
    logic              sel_legal;
    logic [31:0]       rdata_out;

    logic              last_grant_reg;
    logic [1:0]        rsp_valid_reg;
    logic              rsp_err_reg;
    logic              rsp_load_reg;
    logic [31:0]       rdata_hold_reg;

    assign req_valid    = {bus.r1_valid, bus.r0_valid};
    assign req_we       = {bus.r1_we, bus.r0_we};
    assign req_addr[0]  = bus.r0_addr;
    assign req_addr[1]  = bus.r1_addr;
    assign req_wdata[0] = bus.r0_wdata;
    assign req_wdata[1] = bus.r1_wdata;
    assign req_ctl[0]   = bus.r0_ctl;
    assign req_ctl[1]   = bus.r1_ctl;

    // ctl[1:0] encodes the size: 00 byte, 01 half, 10 word, 11 reserved.
    function automatic logic access_legal(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            2'b01:   return (addr_lo[0] == 1'b0);
            2'b10:   return (addr_lo == 2'b00);
            2'b11:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_legal
            assign req_legal[gi] = !ERR_EN || access_legal(req_addr[gi][1:0], req_ctl[gi][1:0]);
        end
    endgenerate

    // Round-robin: on a conflict the requester that did not win last time goes.
    // Nothing is granted while reset is held.
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            if (req_valid == 2'b11) begin
                grant = last_grant_reg ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign any_grant = |grant;
    assign sel       = grant[1];   // idle falls back to r0 on the memory mux
    assign sel_legal = req_legal[sel];

    assign bus.r0_ready = grant[0];
    assign bus.r1_ready = grant[1];
    assign bus.mem_a    = req_addr[sel];
    assign bus.mem_wd   = req_wdata[sel];
    assign bus.mem_ctl  = req_ctl[sel];
    assign bus.mem_we   = any_grant && req_we[sel] && sel_legal;

    // mem_rd is already registered inside the memory, so it is steered straight
    // onto the response bus in the response cycle. Stores and idle cycles keep
    // showing the last value; errors force zero.
    always_comb begin
        rdata_out = rdata_hold_reg;
        if (rsp_err_reg) begin
            rdata_out = 32'h0;
        end else if (rsp_load_reg) begin
            rdata_out = bus.mem_rd;
        end
    end

    assign bus.rsp_rdata    = rdata_out;
    assign bus.rsp_err      = rsp_err_reg;
    assign bus.r0_rsp_valid = rsp_valid_reg[0];
    assign bus.r1_rsp_valid = rsp_valid_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;   // r0 wins the first conflict
            rsp_valid_reg  <= 2'b00;
            rsp_err_reg    <= 1'b0;
            rsp_load_reg   <= 1'b0;
            rdata_hold_reg <= 32'h0;
        end else begin
            if (any_grant) begin
                last_grant_reg <= sel;
            end
            rsp_valid_reg  <= grant;
            rsp_err_reg    <= any_grant && !sel_legal;
            rsp_load_reg   <= any_grant && sel_legal && !req_we[sel];
            rdata_hold_reg <= rdata_out;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32)) bus0();
    dmem_arbiter_if #(.ADDR_W(32)) bus1();

    dmem_arbiter #(.ERR_EN(1'b1), .ADDR_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    dmem_arbiter #(.ERR_EN(1'b0), .ADDR_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // The unchecked instance sees exactly the same requests.
    assign bus1.r0_valid = bus0.r0_valid;
    assign bus1.r1_valid = bus0.r1_valid;
    assign bus1.r0_addr  = bus0.r0_addr;
    assign bus1.r1_addr  = bus0.r1_addr;
    assign bus1.r0_wdata = bus0.r0_wdata;
    assign bus1.r1_wdata = bus0.r1_wdata;
    assign bus1.r0_we    = bus0.r0_we;
    assign bus1.r1_we    = bus0.r1_we;
    assign bus1.r0_ctl   = bus0.r0_ctl;
    assign bus1.r1_ctl   = bus0.r1_ctl;

    // ---------------- memory models (256 bytes, registered read) ----------------
    function automatic logic [31:0] ext_data(input logic [31:0] raw, input logic [2:0] c);
        case (c[1:0])
            2'b00:   return {{24{c[2] & raw[7]}}, raw[7:0]};
            2'b01:   return {{16{c[2] & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    logic [7:0] m0 [256] = '{default: 8'h00};
    logic [7:0] m1 [256] = '{default: 8'h00};

    always @(posedge clk) begin : mem0_blk
        logic [7:0] a;
        a = bus0.mem_a[7:0];
        bus0.mem_rd <= ext_data({m0[8'(a + 8'd3)], m0[8'(a + 8'd2)], m0[8'(a + 8'd1)], m0[a]}, bus0.mem_ctl);
        if (bus0.mem_we) begin
            m0[a] <= bus0.mem_wd[7:0];
            if (bus0.mem_ctl[1:0] != 2'b00) m0[8'(a + 8'd1)] <= bus0.mem_wd[15:8];
            if (bus0.mem_ctl[1]) begin
                m0[8'(a + 8'd2)] <= bus0.mem_wd[23:16];
                m0[8'(a + 8'd3)] <= bus0.mem_wd[31:24];
            end
        end
    end

    always @(posedge clk) begin : mem1_blk
        logic [7:0] a;
        a = bus1.mem_a[7:0];
        bus1.mem_rd <= ext_data({m1[8'(a + 8'd3)], m1[8'(a + 8'd2)], m1[8'(a + 8'd1)], m1[a]}, bus1.mem_ctl);
        if (bus1.mem_we) begin
            m1[a] <= bus1.mem_wd[7:0];
            if (bus1.mem_ctl[1:0] != 2'b00) m1[8'(a + 8'd1)] <= bus1.mem_wd[15:8];
            if (bus1.mem_ctl[1]) begin
                m1[8'(a + 8'd2)] <= bus1.mem_wd[23:16];
                m1[8'(a + 8'd3)] <= bus1.mem_wd[31:24];
            end
        end
    end

    // ---------------- stimulus and reference model ----------------
    int total = 0;
    int bad = 0;

    logic        s_v  [2];
    logic [31:0] s_a  [2];
    logic [31:0] s_d  [2];
    logic        s_we [2];
    logic [2:0]  s_c  [2];

    logic [7:0]  ref_mem [256];
    int          ref_turn;      // requester that wins the next conflict
    int          pend_owner;    // -1 = no response due
    int          pend_kind;     // 0 load, 1 store, 2 error
    logic [31:0] pend_data;
    logic [31:0] last_data;
    int          last_g;

    logic exp_rdy0, exp_rdy1, exp_we, exp_rv0, exp_rv1, exp_err, exp_any;
    logic [31:0] exp_rd, exp_ga, exp_gd;
    logic obs_rdy0, obs_rdy1, obs_we, obs_rv0, obs_rv1, obs_err;
    logic [31:0] obs_rd, obs_ga, obs_gd;
    logic obs1_rv1, obs1_err;
    logic [31:0] obs1_rd;

    function automatic logic is_legal(input logic [31:0] a, input logic [2:0] c);
        case (c[1:0])
            2'b11:   return 1'b0;
            2'b01:   return (a % 32'd2) == 32'd0;
            2'b10:   return (a % 32'd4) == 32'd0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int size_of(input logic [2:0] c);
        return (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] c);
        logic [31:0] v;
        logic [7:0]  idx;
        int n;
        n = size_of(c);
        v = 32'h0;
        for (int k = n - 1; k >= 0; k--) begin
            idx = 8'(a + 32'(k));
            v = (v << 8) | 32'(ref_mem[idx]);
        end
        if (c[2] && n == 1 && v >= 32'd128)   v = v - 32'd256;
        if (c[2] && n == 2 && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        logic [7:0] idx;
        for (int k = 0; k < size_of(c); k++) begin
            idx = 8'(a + 32'(k));
            ref_mem[idx] = 8'(d >> (8 * k));
        end
    endtask

    task automatic model_reset();
        ref_turn   = 0;
        pend_owner = -1;
        pend_kind  = 0;
        pend_data  = 32'h0;
        last_data  = 32'h0;
    endtask

    task automatic apply();
        bus0.r0_valid = s_v[0];  bus0.r1_valid = s_v[1];
        bus0.r0_addr  = s_a[0];  bus0.r1_addr  = s_a[1];
        bus0.r0_wdata = s_d[0];  bus0.r1_wdata = s_d[1];
        bus0.r0_we    = s_we[0]; bus0.r1_we    = s_we[1];
        bus0.r0_ctl   = s_c[0];  bus0.r1_ctl   = s_c[1];
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic [2:0] c);
        s_v[i] = v; s_a[i] = a; s_d[i] = d; s_we[i] = we; s_c[i] = c;
    endtask

    task automatic idle();
        s_v[0] = 1'b0;
        s_v[1] = 1'b0;
    endtask

    // One clock cycle: drive, predict, sample at negedge, advance model at posedge.
    task automatic tick();
        int g;
        logic lg;
        g = -1;
        if (s_v[0] && s_v[1]) g = ref_turn;
        else if (s_v[0])      g = 0;
        else if (s_v[1])      g = 1;
        apply();
        lg       = (g >= 0) ? is_legal(s_a[g], s_c[g]) : 1'b1;
        exp_any  = (g >= 0);
        exp_rdy0 = (g == 0);
        exp_rdy1 = (g == 1);
        exp_we   = (g >= 0) ? (s_we[g] && lg) : 1'b0;
        exp_ga   = (g >= 0) ? s_a[g] : s_a[0];
        exp_gd   = (g >= 0) ? s_d[g] : s_d[0];
        exp_rv0  = (pend_owner == 0);
        exp_rv1  = (pend_owner == 1);
        exp_err  = (pend_owner >= 0) && (pend_kind == 2);
        if (pend_owner >= 0) begin
            if (pend_kind == 0)      last_data = pend_data;
            else if (pend_kind == 2) last_data = 32'h0;
        end
        exp_rd = last_data;
        @(negedge clk);
        obs_rdy0 = bus0.r0_ready;     obs_rdy1 = bus0.r1_ready;
        obs_we   = bus0.mem_we;       obs_ga   = bus0.mem_a;     obs_gd = bus0.mem_wd;
        obs_rv0  = bus0.r0_rsp_valid; obs_rv1  = bus0.r1_rsp_valid;
        obs_err  = bus0.rsp_err;      obs_rd   = bus0.rsp_rdata;
        obs1_rv1 = bus1.r1_rsp_valid; obs1_err = bus1.rsp_err;   obs1_rd = bus1.rsp_rdata;
        @(posedge clk);
        last_g = g;
        if (g >= 0) begin
            ref_turn   = 1 - g;
            pend_owner = g;
            pend_kind  = !lg ? 2 : (s_we[g] ? 1 : 0);
            if (pend_kind == 0) pend_data = ref_load(s_a[g], s_c[g]);
            if (pend_kind == 1) ref_store(s_a[g], s_d[g], s_c[g]);
        end else begin
            pend_owner = -1;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_req(0, 1'b1, 32'h0, 32'h1234_5678, 1'b1, 3'b010);
        set_req(1, 1'b1, 32'h4, 32'h8765_4321, 1'b1, 3'b010);
        apply();
        @(negedge clk);
        total++; if (bus0.r0_ready !== 1'b0 || bus0.r1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b%b want=00", bus0.r0_ready, bus0.r1_ready);
        end
        total++; if (bus0.mem_we !== 1'b0) begin
            bad++; $display("FAIL reset_mem_we got=%b want=0", bus0.mem_we);
        end
        total++; if ({bus0.r0_rsp_valid, bus0.r1_rsp_valid, bus0.rsp_err} !== 3'b000) begin
            bad++; $display("FAIL reset_rsp got=%b%b%b want=000", bus0.r0_rsp_valid, bus0.r1_rsp_valid, bus0.rsp_err);
        end
        total++; if (bus0.rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_rdata got=%h want=00000000", bus0.rsp_rdata);
        end
        @(posedge clk); #1;
        idle();
        model_reset();
        rst_n = 1'b1;
        tick();
        $display("reset: checked");
    endtask

    task automatic test_word_load();
        idle();
        set_req(1, 1'b1, 32'h10, 32'h1122_3344, 1'b1, 3'b010);
        tick();
        total++; if (obs_rdy1 !== 1'b1 || obs_we !== 1'b1) begin
            bad++; $display("FAIL preload_store rdy1/we got=%b/%b want=1/1", obs_rdy1, obs_we);
        end
        idle();
        set_req(0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
        tick();
        total++; if (obs_rdy0 !== 1'b1 || obs_rdy0 !== exp_rdy0) begin
            bad++; $display("FAIL word_load_ready got=%b want=1", obs_rdy0);
        end
        total++; if (obs_rv1 !== exp_rv1 || obs_err !== 1'b0) begin
            bad++; $display("FAIL store_rsp rv1/err got=%b/%b want=%b/0", obs_rv1, obs_err, exp_rv1);
        end
        idle();
        tick();
        total++; if (obs_rv0 !== 1'b1 || obs_err !== 1'b0) begin
            bad++; $display("FAIL word_load_rsp rv0/err got=%b/%b want=1/0", obs_rv0, obs_err);
        end
        total++; if (obs_rd !== 32'h1122_3344 || obs_rd !== exp_rd) begin
            bad++; $display("FAIL word_load_data got=%h want=11223344", obs_rd);
        end
        $display("word_load: rdata=%h", obs_rd);
    endtask

    task automatic test_alternate();
        rst_n = 1'b0;
        idle();
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
        set_req(0, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1, 3'b010);
        set_req(1, 1'b1, 32'h24, 32'hCAFE_F00D, 1'b1, 3'b010);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({obs_rdy0, obs_rdy1} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || obs_we !== 1'b1) begin
                bad++; $display("FAIL alternate_cycle%0d rdy0/rdy1/we got=%b%b%b want=%b1", i, obs_rdy0, obs_rdy1,
                                obs_we, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            $display("alternate: cycle %0d grant r0=%b r1=%b", i, obs_rdy0, obs_rdy1);
        end
        idle();
        set_req(0, 1'b1, 32'h24, 32'h0, 1'b0, 3'b010);
        tick();
        set_req(0, 1'b1, 32'h20, 32'h0, 1'b0, 3'b010);
        tick();
        total++; if (obs_rv0 !== 1'b1 || obs_rd !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL alternate_readback24 rv0/data got=%b/%h want=1/cafef00d", obs_rv0, obs_rd);
        end
        idle();
        tick();
        total++; if (obs_rd !== 32'hDEAD_BEEF || obs_rd !== exp_rd) begin
            bad++; $display("FAIL alternate_readback20 got=%h want=deadbeef", obs_rd);
        end
    endtask

    task automatic test_err_half();
        idle();
        set_req(0, 1'b1, 32'h30, 32'h44CC_BBAA, 1'b1, 3'b010);
        tick();
        idle();
        set_req(1, 1'b1, 32'h31, 32'h0, 1'b0, 3'b001);
        tick();
        total++; if (obs_rdy1 !== 1'b1 || obs_we !== 1'b0) begin
            bad++; $display("FAIL half_misaligned_issue rdy1/we got=%b/%b want=1/0", obs_rdy1, obs_we);
        end
        idle();
        tick();
        total++; if (obs_rv1 !== 1'b1 || obs_err !== 1'b1 || obs_rd !== 32'h0) begin
            bad++; $display("FAIL half_misaligned_rsp rv1/err/data got=%b/%b/%h want=1/1/00000000", obs_rv1, obs_err, obs_rd);
        end
        total++; if (obs1_rv1 !== 1'b1 || obs1_err !== 1'b0 || obs1_rd !== 32'h0000_CCBB) begin
            bad++; $display("FAIL half_unchecked_rsp rv1/err/data got=%b/%b/%h want=1/0/0000ccbb", obs1_rv1, obs1_err, obs1_rd);
        end
        $display("err_half: checked=%h unchecked=%h", obs_rd, obs1_rd);
    endtask

    task automatic test_illegal_store();
        idle();
        set_req(0, 1'b1, 32'h40, 32'h0BAD_F00D, 1'b1, 3'b010);
        tick();
        set_req(0, 1'b1, 32'h40, 32'hFFFF_FFFF, 1'b1, 3'b011);
        tick();
        total++; if (obs_rdy0 !== 1'b1 || obs_we !== 1'b0) begin
            bad++; $display("FAIL illegal_store_issue rdy0/we got=%b/%b want=1/0", obs_rdy0, obs_we);
        end
        set_req(0, 1'b1, 32'h40, 32'h0, 1'b0, 3'b010);
        tick();
        total++; if (obs_rv0 !== 1'b1 || obs_err !== 1'b1 || obs_rd !== 32'h0) begin
            bad++; $display("FAIL illegal_store_rsp rv0/err/data got=%b/%b/%h want=1/1/00000000", obs_rv0, obs_err, obs_rd);
        end
        idle();
        tick();
        total++; if (obs_rd !== 32'h0BAD_F00D || obs_err !== 1'b0) begin
            bad++; $display("FAIL illegal_store_unchanged data/err got=%h/%b want=0badf00d/0", obs_rd, obs_err);
        end
    endtask

    task automatic test_reset_midflight();
        idle();
        set_req(1, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
        tick();
        rst_n = 1'b0;
        set_req(0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
        apply();
        model_reset();
        @(negedge clk);
        total++; if ({bus0.r1_rsp_valid, bus0.r0_ready, bus0.r1_ready, bus0.mem_we} !== 4'b0000) begin
            bad++; $display("FAIL midflight_reset rv1/rdy0/rdy1/we got=%b%b%b%b want=0000", bus0.r1_rsp_valid,
                            bus0.r0_ready, bus0.r1_ready, bus0.mem_we);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        total++; if ({obs_rdy0, obs_rdy1} !== 2'b10 || obs_rv1 !== 1'b0) begin
            bad++; $display("FAIL post_reset_conflict rdy0/rdy1/rv1 got=%b%b%b want=100", obs_rdy0, obs_rdy1, obs_rv1);
        end
        idle();
        tick();
        $display("reset_midflight: first conflict r0=%b", obs_rv0);
    endtask

    task automatic test_back_to_back();
        idle();
        set_req(0, 1'b1, 32'h50, 32'h0000_0080, 1'b1, 3'b000);
        tick();
        set_req(0, 1'b1, 32'h50, 32'h0, 1'b0, 3'b100);
        tick();
        set_req(0, 1'b1, 32'h50, 32'h0, 1'b0, 3'b000);
        tick();
        total++; if (obs_rdy0 !== 1'b1 || obs_rv0 !== 1'b1 || obs_rd !== 32'hFFFF_FF80) begin
            bad++; $display("FAIL b2b_signed rdy0/rv0/data got=%b/%b/%h want=1/1/ffffff80", obs_rdy0, obs_rv0, obs_rd);
        end
        idle();
        tick();
        total++; if (obs_rv0 !== 1'b1 || obs_rd !== 32'h0000_0080) begin
            bad++; $display("FAIL b2b_unsigned rv0/data got=%b/%h want=1/00000080", obs_rv0, obs_rd);
        end
        $display("back_to_back: second rdata=%h", obs_rd);
    endtask

    task automatic test_random();
        logic [2:0] ctl_tab [8];
        int errs_before;
        ctl_tab[0] = 3'b000; ctl_tab[1] = 3'b001; ctl_tab[2] = 3'b010; ctl_tab[3] = 3'b100;
        ctl_tab[4] = 3'b101; ctl_tab[5] = 3'b011; ctl_tab[6] = 3'b010; ctl_tab[7] = 3'b110;
        errs_before = bad;
        idle();
        last_g = -1;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 2; i++) begin
                // a requester that was refused keeps its request unchanged
                if (!(s_v[i] && last_g != i)) begin
                    s_v[i]  = ($urandom_range(0, 9) < 7);
                    s_a[i]  = 32'($urandom_range(0, 255));
                    if ($urandom_range(0, 3) != 0) s_a[i] = s_a[i] & 32'hFFFF_FFFC;
                    s_d[i]  = $urandom;
                    s_we[i] = 1'($urandom_range(0, 1));
                    s_c[i]  = ctl_tab[$urandom_range(0, 7)];
                end
            end
            tick();
            total++; if ({obs_rdy0, obs_rdy1, obs_we, obs_rv0, obs_rv1} !== {exp_rdy0, exp_rdy1, exp_we, exp_rv0, exp_rv1}) begin
                bad++; $display("FAIL rand%0d rdy0/rdy1/we/rv0/rv1 got=%b%b%b%b%b want=%b%b%b%b%b", n, obs_rdy0, obs_rdy1,
                                obs_we, obs_rv0, obs_rv1, exp_rdy0, exp_rdy1, exp_we, exp_rv0, exp_rv1);
            end
            if (exp_any) begin
                total++; if (obs_ga !== exp_ga || (exp_we && obs_gd !== exp_gd)) begin
                    bad++; $display("FAIL rand%0d mem_a/mem_wd got=%h/%h want=%h/%h", n, obs_ga, obs_gd, exp_ga, exp_gd);
                end
            end
            if (exp_rv0 || exp_rv1) begin
                total++; if (obs_err !== exp_err || obs_rd !== exp_rd) begin
                    bad++; $display("FAIL rand%0d err/data got=%b/%h want=%b/%h", n, obs_err, obs_rd, exp_err, exp_rd);
                end
            end
        end
        idle();
        tick();
        $display("random: 300 cycles, new errors=%0d", bad - errs_before);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        model_reset();
        last_g = -1;
        idle();
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
        apply();
        @(posedge clk); #1;
        test_reset();
        test_word_load();
        test_alternate();
        test_err_half();
        test_illegal_store();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the byte-addressable data memory.
- Requester 0 is the core load/store path. Requester 1 is the debug/DMA port.
- Grants one access per cycle using round-robin priority. Drives the memory's address, write-data, write-enable and ctl signals, and routes the registered read data back to the owner one cycle later.
- Optionally rejects misaligned or illegal accesses with an error response, without touching memory.

Parameters:
- ERR_EN, 1: 1 enables the alignment/ctl legality check; 0 passes every request to memory unchecked.
- ADDR_W, 32: request and memory address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_valid, r1_valid  in  1 each  request valid
- r0_ready, r1_ready  out  1 each  request accepted this cycle (combinational grant)
- r0_addr, r1_addr  in  ADDR_W each  byte address
- r0_wdata, r1_wdata  in  32 each  store data
- r0_we, r1_we  in  1 each  1 = store, 0 = load
- r0_ctl, r1_ctl  in  3 each  size/sign code: 000 bu, 001 hu, 010 w, 100 b, 101 h
- r0_rsp_valid, r1_rsp_valid  out  1 each  response strobe, single cycle
- rsp_rdata  out  32  load data (shared bus, valid with the owner's rsp_valid)
- rsp_err  out  1  response is an error (shared, qualified by rsp_valid)
- mem_a  out  ADDR_W  memory address
- mem_wd  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_ctl  out  3  memory ctl
- mem_rd  in  32  memory read data (registered inside the memory; valid the cycle after a load issue)

Behaviour:
- Reset (async, rst_n=0): r*_rsp_valid=0, rsp_err=0, rsp_rdata=0, last_grant=1 (so r0 wins the first conflict), pending-owner register cleared.
  - Combinational outputs during reset: r*_ready=0, mem_we=0.
  - A response pending when reset asserts is dropped.
- Grant (combinational, every cycle):
  - Only r0_valid → grant 0. Only r1_valid → grant 1.
  - Both valid → grant !last_grant.
  - On any grant, last_grant <= granted index.
  - ready is asserted only to the granted requester. A request is accepted when valid && ready.
  - Requesters hold addr/wdata/we/ctl stable while valid && !ready.
- Memory drive:
  - mem_a, mem_wd, mem_ctl are muxed from the granted requester, or from r0 when idle (don't-care).
  - mem_we = granted && we && legal. Never 1 without a legal grant.
- Legality (ERR_EN=1):
  - Illegal if ctl[1:0]=11.
  - Illegal if a half access (ctl[1:0]=01) has addr[0]=1.
  - Illegal if a word access (ctl[1:0]=10) has addr[1:0]≠0.
  - An illegal request is still accepted (ready=1) but mem_we is forced 0.
- Response pipeline (registered, latency 1):
  - The cycle after acceptance, rsp_valid is pulsed for the owner.
  - Load: rsp_rdata = mem_rd, rsp_err=0.
  - Store: rsp_rdata holds its previous value, rsp_err=0.
  - Illegal access: rsp_err=1, rsp_rdata=0.
- Throughput: back-to-back issue every cycle, no bubbles. A new grant may be issued in the same cycle a previous response is returned.
- No response backpressure: requesters must sink rsp_valid in the cycle it appears.
- Simultaneous cases:
  - The same requester may re-request in its own response cycle.
  - With both requesters continuously valid, grants alternate 0,1,0,1.

Test Plan:
- Reset then r0 load addr 0x10, ctl 010, with memory preloaded 0x10..0x13 = 44 33 22 11 → r0_ready=1 in cycle 0; r0_rsp_valid=1 in cycle 1 with rsp_rdata=0x11223344, rsp_err=0.
- r0 and r1 both continuously valid for 4 cycles, r0 storing word 0xDEADBEEF to 0x20 and r1 storing 0xCAFEF00D to 0x24 → grant order 0,1,0,1; mem_we=1 every cycle; a later word load from 0x24 returns 0xCAFEF00D.
- r1 half load at addr 0x31 with ERR_EN=1 → r1_ready=1, mem_we=0; next cycle r1_rsp_valid=1, rsp_err=1, rsp_rdata=0. With ERR_EN=0 the same request returns memory data and rsp_err=0.
- r0 store with ctl 011 at 0x40 → mem_we stays 0; error response returned; a subsequent load of 0x40 shows the old contents unchanged.
- Assert rst_n=0 in the cycle after r1 issues a load → r1_rsp_valid never pulses; after release, the first r0/r1 conflict is granted to r0.
- r0 signed byte load (ctl 100) of 0x80 at 0x50, immediately followed by an r0 unsigned byte load (ctl 000) of the same address → responses on consecutive cycles: 0xFFFFFF80, then 0x00000080.
